// File: rtl/tv80_alu16_pkg.sv
// Shared types and constants for the 16-bit TV80 ALU sequencer: op codes, FSM states,
// 8-bit ALU_Op encodings and flag bit positions (identical to the TV80 ALU).
package tv80_alu16_pkg;

    typedef enum logic [2:0] {
        OP_ADD16 = 3'b000,
        OP_ADC16 = 3'b001,
        OP_SBC16 = 3'b011,
        OP_INC16 = 3'b100,
        OP_DEC16 = 3'b110
    } op_e;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LO   = 2'd1;
    localparam logic [1:0] ST_HI   = 2'd2;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_ADC = 4'b0001;
    localparam logic [3:0] ALU_SUB = 4'b0010;
    localparam logic [3:0] ALU_SBC = 4'b0011;

    localparam int Flag_C = 0;
    localparam int Flag_N = 1;
    localparam int Flag_P = 2;
    localparam int Flag_X = 3;
    localparam int Flag_H = 4;
    localparam int Flag_Y = 5;
    localparam int Flag_Z = 6;
    localparam int Flag_S = 7;

endpackage

// File: rtl/tv80_alu16_seq_if.sv
// Request/response and 8-bit ALU bus of the 16-bit sequencer. The master is the
// surrounding datapath (issues requests, hosts the ALU); the slave is the sequencer.
interface tv80_alu16_seq_if;

    logic        start;
    logic [2:0]  op;
    logic [15:0] opa;
    logic [15:0] opb;
    logic [7:0]  f_in;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] result;
    logic [7:0]  f_out;
    logic [3:0]  alu_op;
    logic        alu_arith16;
    logic        alu_z16;
    logic [7:0]  alu_busa;
    logic [7:0]  alu_busb;
    logic [7:0]  alu_f_in;
    logic [7:0]  alu_q;
    logic [7:0]  alu_f_out;

    modport master (
        output start, op, opa, opb, f_in, alu_q, alu_f_out,
        input  busy, done, err, result, f_out,
        input  alu_op, alu_arith16, alu_z16, alu_busa, alu_busb, alu_f_in
    );

    modport slave (
        input  start, op, opa, opb, f_in, alu_q, alu_f_out,
        output busy, done, err, result, f_out,
        output alu_op, alu_arith16, alu_z16, alu_busa, alu_busb, alu_f_in
    );

endinterface

// File: rtl/tv80_alu16_seq.sv
// Runs 16-bit ADD/ADC/SBC through the external 8-bit TV80 ALU as a low then a high byte pass.
// Define TV80_ALU16_INCDEC_EN to make INC16/DEC16 legal; otherwise they raise err.
module tv80_alu16_seq
    import tv80_alu16_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    tv80_alu16_seq_if.slave bus
);

    logic [1:0]  state_q, state_d;
    logic [2:0]  op_q;
    logic [15:0] opa_q, opb_q;
    logic [7:0]  fin_q, q_lo_q, f_lo_q;
    logic [15:0] result_q;
    logic [7:0]  f_out_q;
    logic        done_q, err_q;

    logic        op_legal;
    logic        hi_pass;
    logic        keep_flags;
    logic [3:0]  alu_op_d;
    logic        arith16_d, z16_d;
    logic [7:0]  busa_d, busb_d, alu_f_in_d;

    always_comb begin
        op_legal = 1'b0;
        case (bus.op)
            OP_ADD16, OP_ADC16, OP_SBC16: op_legal = 1'b1;
`ifdef TV80_ALU16_INCDEC_EN
            OP_INC16, OP_DEC16:           op_legal = 1'b1;
`endif
            default:                      op_legal = 1'b0;
        endcase
    end

`ifdef TV80_ALU16_INCDEC_EN
    // INC/DEC only borrow the ALU's carry chain; the caller's flags pass through untouched.
    assign keep_flags = (op_q == OP_INC16) || (op_q == OP_DEC16);
`else
    assign keep_flags = 1'b0;
`endif

    assign hi_pass = (state_q == ST_HI);

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        alu_op_d   = 4'b0000;
        arith16_d  = 1'b0;
        z16_d      = 1'b0;
        busa_d     = 8'h00;
        busb_d     = 8'h00;
        alu_f_in_d = 8'h00;
        state_d    = state_q;
        if (state_q != ST_IDLE) begin
            busa_d     = hi_pass ? opa_q[15:8] : opa_q[7:0];
            busb_d     = hi_pass ? opb_q[15:8] : opb_q[7:0];
            alu_f_in_d = hi_pass ? f_lo_q : fin_q;
            case (op_q)
                OP_ADD16: begin
                    alu_op_d  = hi_pass ? ALU_ADC : ALU_ADD;
                    arith16_d = 1'b1;
                end
                OP_ADC16: begin
                    alu_op_d = ALU_ADC;
                    z16_d    = hi_pass;
                end
                OP_SBC16: begin
                    alu_op_d = ALU_SBC;
                    z16_d    = hi_pass;
                end
`ifdef TV80_ALU16_INCDEC_EN
                OP_INC16: begin
                    alu_op_d = hi_pass ? ALU_ADC : ALU_ADD;
                    busb_d   = hi_pass ? 8'h00 : 8'h01;
                end
                OP_DEC16: begin
                    alu_op_d = hi_pass ? ALU_SBC : ALU_SUB;
                    busb_d   = hi_pass ? 8'h00 : 8'h01;
                end
`endif
                default: alu_op_d = 4'b0000;
            endcase
        end
        case (state_q)
            ST_IDLE: if (bus.start && op_legal) state_d = ST_LO;
            ST_LO:   state_d = ST_HI;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: every register here, operand latches included, is cleared by the async reset
    // so a reset mid-operation leaves nothing stale behind.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            op_q     <= 3'b000;
            opa_q    <= 16'h0000;
            opb_q    <= 16'h0000;
            fin_q    <= 8'h00;
            q_lo_q   <= 8'h00;
            f_lo_q   <= 8'h00;
            result_q <= 16'h0000;
            f_out_q  <= 8'h00;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            state_q <= state_d;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start && op_legal) begin
                        op_q  <= bus.op;
                        opa_q <= bus.opa;
                        opb_q <= bus.opb;
                        fin_q <= bus.f_in;
                    end else if (bus.start) begin
                        err_q <= 1'b1;
                    end
                end
                ST_LO: begin
                    q_lo_q <= bus.alu_q;
                    f_lo_q <= bus.alu_f_out;
                end
                default: begin
                    result_q <= {bus.alu_q, q_lo_q};
                    f_out_q  <= keep_flags ? fin_q : bus.alu_f_out;
                    done_q   <= 1'b1;
                end
            endcase
        end
    end

    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.done        = done_q;
    assign bus.err         = err_q;
    assign bus.result      = result_q;
    assign bus.f_out       = f_out_q;
    assign bus.alu_op      = alu_op_d;
    assign bus.alu_arith16 = arith16_d;
    assign bus.alu_z16     = z16_d;
    assign bus.alu_busa    = busa_d;
    assign bus.alu_busb    = busb_d;
    assign bus.alu_f_in    = alu_f_in_d;

endmodule

// File: tb/tb_tv80_alu16_seq.sv
// Self-checking bench: a byte-level TV80 ALU model answers the sequencer, and results are
// compared with a 16-bit Z80 arithmetic reference model.
module tb_tv80_alu16_seq;
    import tv80_alu16_pkg::*;

    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    logic [15:0] last_res = 16'h0000;
    logic [7:0]  last_f   = 8'h00;

    tv80_alu16_seq_if bus();

    tv80_alu16_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte-wide TV80 ALU behaviour for ALU_Op 0000..0011; returns {Q, F_Out}.
    function automatic logic [15:0] alu8(input logic [3:0] aop, input logic ar16, input logic z16,
                                         input logic [7:0] a, input logic [7:0] b, input logic [7:0] fi);
        logic       sub, cin, c, hc;
        logic [7:0] bb, q, f;
        logic [8:0] s;
        logic [4:0] hs;
        sub = aop[1];
        cin = aop[0] & fi[Flag_C];
        bb  = sub ? ~b : b;
        if (sub) cin = ~cin;
        s   = {1'b0, a} + {1'b0, bb} + {8'h00, cin};
        hs  = {1'b0, a[3:0]} + {1'b0, bb[3:0]} + {4'h0, cin};
        q   = s[7:0];
        c   = s[8];
        hc  = hs[4];
        f = 8'h00;
        f[Flag_C] = sub ? ~c : c;
        f[Flag_H] = sub ? ~hc : hc;
        f[Flag_P] = (a[7] == bb[7]) && (q[7] != a[7]);
        f[Flag_N] = sub;
        f[Flag_X] = q[3];
        f[Flag_Y] = q[5];
        f[Flag_S] = q[7];
        f[Flag_Z] = (q == 8'h00) && (z16 ? fi[Flag_Z] : 1'b1);
        if (ar16) begin
            f[Flag_S] = fi[Flag_S];
            f[Flag_Z] = fi[Flag_Z];
            f[Flag_P] = fi[Flag_P];
        end
        if (aop[3:2] != 2'b00) begin
            q = 8'h00;
            f = 8'h00;
        end
        return {q, f};
    endfunction

    always_comb {bus.alu_q, bus.alu_f_out} =
        alu8(bus.alu_op, bus.alu_arith16, bus.alu_z16, bus.alu_busa, bus.alu_busb, bus.alu_f_in);

    function automatic logic legal_op(input logic [2:0] op);
        case (op)
            3'b000, 3'b001, 3'b011: return 1'b1;
`ifdef TV80_ALU16_INCDEC_EN
            3'b100, 3'b110: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    // 16-bit Z80 semantics computed directly on the whole words; returns {result, flags}.
    function automatic logic [23:0] ref16(input logic [2:0] op, input logic [15:0] a,
                                          input logic [15:0] b, input logic [7:0] f);
        int unsigned ua, ub, c, full, half;
        logic [15:0] r;
        logic [7:0]  o;
        ua = a; ub = b; c = f[Flag_C];
        r = 16'h0000;
        o = f;
        case (op)
            3'b000: begin
                full = ua + ub;
                half = (ua & 32'hFFF) + (ub & 32'hFFF);
                r = full[15:0];
                o = f & 8'hC4;
                o[Flag_C] = full > 32'hFFFF;
                o[Flag_H] = half > 32'hFFF;
                o[Flag_X] = r[11];
                o[Flag_Y] = r[13];
            end
            3'b001: begin
                full = ua + ub + c;
                half = (ua & 32'hFFF) + (ub & 32'hFFF) + c;
                r = full[15:0];
                o = 8'h00;
                o[Flag_C] = full > 32'hFFFF;
                o[Flag_H] = half > 32'hFFF;
                o[Flag_P] = (a[15] == b[15]) && (r[15] != a[15]);
                o[Flag_S] = r[15];
                o[Flag_Z] = (r == 16'h0000);
                o[Flag_X] = r[11];
                o[Flag_Y] = r[13];
            end
            3'b011: begin
                r = a - b - 16'(c);
                o = 8'h00;
                o[Flag_N] = 1'b1;
                o[Flag_C] = ua < ub + c;
                o[Flag_H] = (ua & 32'hFFF) < (ub & 32'hFFF) + c;
                o[Flag_P] = (a[15] != b[15]) && (r[15] != a[15]);
                o[Flag_S] = r[15];
                o[Flag_Z] = (r == 16'h0000);
                o[Flag_X] = r[11];
                o[Flag_Y] = r[13];
            end
            3'b100:  r = a + 16'd1;
            3'b110:  r = a - 16'd1;
            default: r = 16'h0000;
        endcase
        return {r, o};
    endfunction

    // ALU_Op per pass from the control table; returns {lo, hi}.
    function automatic logic [7:0] pass_ops(input logic [2:0] op);
        case (op)
            3'b000:  return {4'b0000, 4'b0001};
            3'b001:  return {4'b0001, 4'b0001};
            3'b011:  return {4'b0011, 4'b0011};
            3'b100:  return {4'b0000, 4'b0001};
            default: return {4'b0010, 4'b0011};
        endcase
    endfunction

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issues one request from a negedge and checks every cycle through done (or err).
    task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic [7:0] f);
        logic [23:0] r;
        logic [7:0]  ops;
        r   = ref16(op, a, b, f);
        ops = pass_ops(op);
        bus.start = 1'b1;
        bus.op    = op;
        bus.opa   = a;
        bus.opb   = b;
        bus.f_in  = f;
        @(negedge clk);
        bus.start = 1'b0;
        bus.opa   = 16'($urandom);
        bus.opb   = 16'($urandom);
        bus.f_in  = 8'($urandom);
        check("done_clear", 16'(bus.done), 16'h0);
        if (!legal_op(op)) begin
            check("err", 16'(bus.err), 16'h1);
            check("ill_busy", 16'(bus.busy), 16'h0);
            check("ill_result", bus.result, last_res);
            check("ill_f_out", 16'(bus.f_out), 16'(last_f));
            check("ill_alu_op", 16'(bus.alu_op), 16'h0);
            @(negedge clk);
            check("err_pulse", 16'(bus.err), 16'h0);
            check("ill_no_done", 16'(bus.done), 16'h0);
        end else begin
            check("lo_busy", 16'(bus.busy), 16'h1);
            check("lo_alu_op", 16'(bus.alu_op), 16'(ops[7:4]));
            check("lo_busa", 16'(bus.alu_busa), 16'(a[7:0]));
            check("lo_f_in", 16'(bus.alu_f_in), 16'(f));
            @(negedge clk);
            check("hi_busy", 16'(bus.busy), 16'h1);
            check("hi_alu_op", 16'(bus.alu_op), 16'(ops[3:0]));
            check("hi_busa", 16'(bus.alu_busa), 16'(a[15:8]));
            check("hi_no_done", 16'(bus.done), 16'h0);
            @(negedge clk);
            check("done", 16'(bus.done), 16'h1);
            check("done_busy", 16'(bus.busy), 16'h0);
            check("result", bus.result, r[23:8]);
            check("f_out", 16'(bus.f_out), 16'(r[7:0]));
            last_res = r[23:8];
            last_f   = r[7:0];
        end
    endtask

    initial begin
        logic [2:0] rop;
        logic [2:0] illegal_ops [3];
        illegal_ops[0] = 3'b010;
        illegal_ops[1] = 3'b101;
        illegal_ops[2] = 3'b111;

        bus.start = 1'b0;
        bus.op    = 3'b000;
        bus.opa   = 16'h0000;
        bus.opb   = 16'h0000;
        bus.f_in  = 8'h00;
        reset     = 1'b1;
        #2;
        check("rst_busy", 16'(bus.busy), 16'h0);
        check("rst_done", 16'(bus.done), 16'h0);
        check("rst_err", 16'(bus.err), 16'h0);
        check("rst_result", bus.result, 16'h0000);
        check("rst_f_out", 16'(bus.f_out), 16'h00);
        check("rst_alu_op", 16'(bus.alu_op), 16'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Directed cases from the worked examples.
        run_op(3'b000, 16'h0FFF, 16'h0001, 8'hC4);
        run_op(3'b001, 16'hFFFF, 16'h0000, 8'h01);
        run_op(3'b011, 16'h8000, 16'h0001, 8'h00);
        run_op(3'b011, 16'h0034, 16'h0000, 8'h00);
        run_op(3'b011, 16'h1234, 16'h1234, 8'h00);
        run_op(3'b101, 16'h5555, 16'hAAAA, 8'hFF);
        run_op(3'b100, 16'hFFFF, 16'h1234, 8'hA5);
        run_op(3'b110, 16'h0000, 16'h0000, 8'h5A);

        // Start held high: accepted at e0, e3, e6 only.
        bus.start = 1'b1;
        bus.op    = 3'b000;
        bus.opa   = 16'h1111;
        bus.opb   = 16'h2222;
        bus.f_in  = 8'h00;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            check("hold_busy", 16'(bus.busy), 16'((k % 3) != 2));
            check("hold_done", 16'(bus.done), 16'((k % 3) == 2));
        end
        check("hold_result", bus.result, 16'h3333);
        last_res  = 16'h3333;
        last_f    = 8'h00;
        bus.start = 1'b0;
        @(negedge clk);

        // Reset while in HI abandons the op.
        bus.start = 1'b1;
        bus.op    = 3'b001;
        bus.opa   = 16'h4321;
        bus.opb   = 16'h1111;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        check("pre_rst_hi", 16'(bus.busy), 16'h1);
        reset = 1'b1;
        #1;
        check("mid_rst_busy", 16'(bus.busy), 16'h0);
        check("mid_rst_result", bus.result, 16'h0000);
        check("mid_rst_f_out", 16'(bus.f_out), 16'h00);
        check("mid_rst_alu_op", 16'(bus.alu_op), 16'h0);
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_no_done", 16'(bus.done), 16'h0);
        @(negedge clk);
        check("post_rst_no_done", 16'(bus.done), 16'h0);
        check("post_rst_busy", 16'(bus.busy), 16'h0);
        last_res = 16'h0000;
        last_f   = 8'h00;

        // Randomized mix, with operand corners mixed in.
        for (int i = 0; i < 80; i++) begin
            logic [15:0] a, b;
            case ($urandom_range(0, 5))
                0: rop = 3'b000;
                1: rop = 3'b001;
                2: rop = 3'b011;
                3: rop = 3'b100;
                4: rop = 3'b110;
                default: rop = illegal_ops[$urandom_range(0, 2)];
            endcase
            a = 16'($urandom);
            b = 16'($urandom);
            if ($urandom_range(0, 3) == 0) a = ($urandom_range(0, 1) != 0) ? 16'hFFFF : 16'h0000;
            if ($urandom_range(0, 3) == 0) b = ($urandom_range(0, 1) != 0) ? 16'hFFFF : a;
            run_op(rop, a, b, 8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
